spi_byte_arbiter: RTL and testbench
===================================

# spi_byte_arbiter

Round-robin arbiter and sequencer that shares one `spi_master` byte engine between `NUM_REQ` requesters (e.g. LCD init sequencer, framebuffer writer, register reader). Each requester streams a burst of bytes (command/data flagged by `dc`). The grant is held for the whole burst so bytes from different requesters never interleave. The block drives the `spi_master` `send_en`/`send_busy` handshake and returns each received MISO byte to the granted requester.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `BUSY_TIMEOUT`, 64: cycles allowed for `send_busy` to rise after `send_en`, ≥2.

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `NUM_REQ`: requester i has a byte to send.
- `req_dc` in `NUM_REQ`: per-requester D/C flag (0 = cmd, 1 = data).
- `req_data` in `NUM_REQ`×8: per-requester byte.
- `req_last` in `NUM_REQ`: byte is the final byte of the burst.
- `req_ready` out `NUM_REQ`: byte accepted this cycle; one-hot or zero.
- `grant` out `NUM_REQ`: one-hot owner of the bus, zero when idle.
- `rsp_valid` out `NUM_REQ`: one-cycle pulse when the granted requester's byte completes.
- `rsp_data` out 8: received byte, valid with `rsp_valid`.
- `err_timeout` out 1: one-cycle pulse on busy timeout.
- `send_en` out 1, `send_dc` out 1, `send_data` out 8: to `spi_master`.
- `send_busy` in 1, `recv_data` in 8: from `spi_master`.

## Operation
States: IDLE, ARB, ISSUE, WAIT_BUSY, WAIT_DONE.

- **IDLE:** stay while `send_busy`=1. This covers a master still running after reset. Otherwise go to ARB.
- **ARB:**
  - If any `req_valid`, pick the first asserted index starting at `rr_ptr` and searching upward with wrap.
  - Set `grant` to that index and go to ISSUE.
  - If none is asserted, stay in ARB.
- **ISSUE:**
  - If `req_valid[g]`: assert `req_ready[g]` combinationally.
  - On the same edge, register `send_data`/`send_dc` from requester g, set `send_en`=1, latch `req_last[g]` into `last_q`, clear the timeout counter, and go to WAIT_BUSY.
  - If `req_valid[g]`=0: hold `grant` and wait indefinitely.
- **WAIT_BUSY:**
  - `send_en` stays 1 until `send_busy`=1 is sampled. On that edge `send_en`←0 and the state goes to WAIT_DONE.
  - The counter increments each cycle. When it reaches `BUSY_TIMEOUT`: `send_en`←0, pulse `err_timeout`, clear `grant`, `rr_ptr`←g+1 mod `NUM_REQ`, go to ARB, and assert no `rsp_valid`.
- **WAIT_DONE:**
  - On `send_busy`=0: pulse `rsp_valid[g]` and register `rsp_data`←`recv_data`.
  - If `last_q`: clear `grant`, `rr_ptr`←g+1 mod `NUM_REQ`, go to ARB.
  - Otherwise go to ISSUE with the same grant.
- **Simultaneous requests:** resolved only in ARB; requests arriving mid-burst wait.
- **Pointers:** `rr_ptr` width is `$clog2(NUM_REQ)`, with explicit wrap for non-power-of-2 `NUM_REQ`.
- **Reset:**
  - Values: `send_en`, `grant`, `req_ready`, `rsp_valid`, `err_timeout`, `rr_ptr`, `send_dc` are 0; `send_data`, `rsp_data` are 0x00; state is IDLE.
  - Reset mid-burst abandons the burst with no response. The in-flight master byte completes unobserved, guarded by IDLE.

## Timing
- ARB→ISSUE: 1 cycle. `req_ready` is accepted at the earliest one cycle after `grant` rises.
- `send_en` rises the cycle after `req_ready`.
- `rsp_valid` occurs 1 cycle after `send_busy` is sampled low.
- Burst-to-burst gap: the next `grant` appears ≥1 cycle after the last `rsp_valid` (ARB cycle).
- Zero-length bursts do not exist; a burst is ≥1 byte, terminated by `req_last`.
- `req_data`/`req_dc`/`req_last` are sampled only when `req_ready` is high.

## Structure
- Package `spi_arb_pkg` holds the state enum `arb_state_t` and the constants `RS_CMD`=0 and `RS_DAT`=1.
- Sub-module `spi_rr_pick`: combinational round-robin picker. Inputs: `req` vector and `ptr`. Outputs: one-hot `pick` and `any`.
- The top level instantiates the arbiter next to `spi_master`.

## Test plan
- **Single burst:** req0 sends 3 bytes 0x2A(cmd), 0x00, 0x3F(data, last). Required: `send_dc` = 0,1,1 respectively; 3 `rsp_valid[0]` pulses; `grant` clears after the third.
- **Round-robin:** req0–req3 all valid with 1-byte bursts from reset. Required: grants in order 0,1,2,3,0. With `rr_ptr`=2, only req0 and req3 valid → req3 first.
- **Non-interleave:** req1 gets a 4-byte burst; req2 asserts during byte 2. Required: req2's byte is issued only after req1's 4th `rsp_valid`.
- **Stall:** granted requester drops `req_valid` for 10 cycles mid-burst. Required: `grant` held, `send_en` stays 0, and the burst resumes.
- **Timeout:** tie `send_busy`=0 in the model. Required: `err_timeout` pulses `BUSY_TIMEOUT` cycles after `send_en` rises; `grant` clears; the next requester is served.
- **Reset:** assert `rst` during WAIT_DONE with `send_busy`=1. Required: all outputs are 0 next cycle; no issue until `send_busy` falls.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared types and constants for the SPI byte arbiter
package spi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

    localparam logic RS_CMD = 1'b0;
    localparam logic RS_DAT = 1'b1;

endpackage

// File: rtl/spi_rr_pick.sv
// rtl/spi_rr_pick.sv - combinational round-robin picker, searches upward from ptr with wrap
module spi_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               any
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    always_comb begin
        pick = '0;
        any  = 1'b0;
        sum  = '0;
        idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // explicit wrap keeps non-power-of-2 requester counts in range
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NUM_REQ)) begin
                sum = sum - (PW+1)'(NUM_REQ);
            end
            idx = sum[PW-1:0];
            if (!any && req[idx]) begin
                pick[idx] = 1'b1;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_byte_arbiter.sv
// rtl/spi_byte_arbiter.sv - round-robin burst arbiter sharing one spi_master byte engine
module spi_byte_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_dc,
    input  logic [NUM_REQ-1:0][7:0] req_data,
    input  logic [NUM_REQ-1:0]      req_last,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      grant,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [7:0]              rsp_data,
    output logic                    err_timeout,
    output logic                    send_en,
    output logic                    send_dc,
    output logic [7:0]              send_data,
    input  logic                    send_busy,
    input  logic [7:0]              recv_data
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    arb_state_t         state;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      g_idx;
    logic [PW-1:0]      g_next;
    logic [PW-1:0]      pick_idx;
    logic [NUM_REQ-1:0] pick;
    logic               pick_any;
    logic               last_q;
    logic [CW-1:0]      busy_cnt;

    spi_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_pick (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .pick (pick),
        .any  (pick_any)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                pick_idx = PW'(i);
            end
        end
    end

    assign g_next    = (g_idx == PW'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
    assign req_ready = (state == ISSUE) ? (grant & req_valid) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            g_idx       <= '0;
            last_q      <= 1'b0;
            busy_cnt    <= '0;
            send_en     <= 1'b0;
            send_dc     <= 1'b0;
            send_data   <= 8'h00;
            rsp_valid   <= '0;
            rsp_data    <= 8'h00;
            err_timeout <= 1'b0;
        end else begin
            rsp_valid   <= '0;
            err_timeout <= 1'b0;
            case (state)
                // a master byte may still be running after reset; never overlap it
                IDLE: begin
                    if (!send_busy) begin
                        state <= ARB;
                    end
                end
                ARB: begin
                    if (pick_any) begin
                        grant <= pick;
                        g_idx <= pick_idx;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (req_valid[g_idx]) begin
                        send_data <= req_data[g_idx];
                        send_dc   <= req_dc[g_idx];
                        last_q    <= req_last[g_idx];
                        send_en   <= 1'b1;
                        busy_cnt  <= '0;
                        state     <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (send_busy) begin
                        send_en <= 1'b0;
                        state   <= WAIT_DONE;
                    end else if (busy_cnt == CW'(BUSY_TIMEOUT - 1)) begin
                        send_en     <= 1'b0;
                        err_timeout <= 1'b1;
                        grant       <= '0;
                        rr_ptr      <= g_next;
                        state       <= ARB;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!send_busy) begin
                        rsp_valid <= grant;
                        rsp_data  <= recv_data;
                        if (last_q) begin
                            grant  <= '0;
                            rr_ptr <= g_next;
                            state  <= ARB;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_byte_arbiter.sv
// tb/tb_spi_byte_arbiter.sv - directed self-checking bench for spi_byte_arbiter
module tb_spi_byte_arbiter;
    import spi_arb_pkg::*;

    localparam int N  = 4;
    localparam int BT = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_dc;
    logic [N-1:0][7:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    grant;
    logic [N-1:0]    rsp_valid;
    logic [7:0]      rsp_data;
    logic            err_timeout;
    logic            send_en;
    logic            send_dc;
    logic [7:0]      send_data;
    logic            send_busy;
    logic [7:0]      recv_data;

    spi_byte_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(BT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_dc      (req_dc),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .grant       (grant),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .err_timeout (err_timeout),
        .send_en     (send_en),
        .send_dc     (send_dc),
        .send_data   (send_data),
        .send_busy   (send_busy),
        .recv_data   (recv_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int enc(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    // requester queues: {dc, last, data}
    logic [9:0] rq [N][$];
    logic [N-1:0] hold = '0;

    initial begin
        logic [N-1:0] tk;
        req_valid = '0; req_dc = '0; req_data = '0; req_last = '0;
        forever begin
            @(negedge clk);
            tk = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (tk[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                if (rq[i].size() > 0 && !hold[i]) begin
                    req_valid[i] = 1'b1;
                    {req_dc[i], req_last[i], req_data[i]} = rq[i][0];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // spi_master model: busy rises the negedge after send_en, echoes ~data
    int  busy_len = 3;
    bit  model_on = 1'b1;
    initial begin
        int mcnt;
        logic [7:0] last_sent;
        send_busy = 1'b0; recv_data = 8'h00; mcnt = 0; last_sent = 8'h00;
        forever begin
            @(negedge clk);
            if (send_busy) begin
                mcnt--;
                if (mcnt <= 0) begin
                    send_busy = 1'b0;
                    recv_data = ~last_sent;
                end
            end else if (model_on && send_en) begin
                send_busy = 1'b1;
                mcnt      = busy_len;
                last_sent = send_data;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int send_idx[$], send_dcq[$], send_dat[$], send_cyc[$];
    int rsp_idx[$], rsp_dat[$], rsp_cyc[$];
    int to_cyc[$], to_grant[$];

    initial begin
        logic se_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (send_en && !se_prev) begin
                send_idx.push_back(enc(grant));
                send_dcq.push_back(int'(send_dc));
                send_dat.push_back(int'(send_data));
                send_cyc.push_back(cyc);
            end
            se_prev = send_en;
            if (|rsp_valid) begin
                rsp_idx.push_back(enc(rsp_valid));
                rsp_dat.push_back(int'(rsp_data));
                rsp_cyc.push_back(cyc);
            end
            if (err_timeout) begin
                to_cyc.push_back(cyc);
                to_grant.push_back(int'(grant));
            end
        end
    end

    task automatic clear_logs();
        send_idx.delete(); send_dcq.delete(); send_dat.delete(); send_cyc.delete();
        rsp_idx.delete(); rsp_dat.delete(); rsp_cyc.delete();
        to_cyc.delete(); to_grant.delete();
    endtask

    task automatic wait_rsp(input string tag, input int n, input int budget);
        int k = 0;
        while (rsp_idx.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check({tag, "_rsp_count"}, rsp_idx.size(), n);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_grant"}, int'(grant), 0);
        check({tag, "_send_en"}, int'(send_en), 0);
        check({tag, "_req_ready"}, int'(req_ready), 0);
        check({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        check({tag, "_err_timeout"}, int'(err_timeout), 0);
        check({tag, "_send_data"}, int'(send_data), 0);
        check({tag, "_send_dc"}, int'(send_dc), 0);
        check({tag, "_rsp_data"}, int'(rsp_data), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        int k;
        int b_dc[3];
        int b_dat[3];
        int rr_ord[5];
        b_dc  = '{0, 1, 1};
        b_dat = '{'h2A, 'h00, 'h3F};
        rr_ord = '{0, 1, 2, 3, 0};

        // reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        // single burst on req0
        clear_logs();
        rq[0].push_back({RS_CMD, 1'b0, 8'h2A});
        rq[0].push_back({RS_DAT, 1'b0, 8'h00});
        rq[0].push_back({RS_DAT, 1'b1, 8'h3F});
        wait_rsp("single", 3, 200);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("single_idx%0d", i), send_idx[i], 0);
            check($sformatf("single_dc%0d", i), send_dcq[i], b_dc[i]);
            check($sformatf("single_dat%0d", i), send_dat[i], b_dat[i]);
            check($sformatf("single_rsp%0d", i), rsp_dat[i], (~b_dat[i]) & 'hFF);
            check($sformatf("single_rspidx%0d", i), rsp_idx[i], 0);
        end
        check("single_grant_clear", int'(grant), 0);

        // round robin from reset: 0,1,2,3,0
        @(negedge clk);
        rst = 1'b1;
        clear_logs();
        rq[0].push_back({RS_DAT, 1'b1, 8'h10});
        rq[0].push_back({RS_DAT, 1'b1, 8'h14});
        rq[1].push_back({RS_DAT, 1'b1, 8'h11});
        rq[2].push_back({RS_DAT, 1'b1, 8'h12});
        rq[3].push_back({RS_DAT, 1'b1, 8'h13});
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_rsp("rr", 5, 300);
        for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), send_idx[i], rr_ord[i]);
        // serve req1 alone so rr_ptr becomes 2, then req0+req3 together -> req3 first
        rq[1].push_back({RS_DAT, 1'b1, 8'h21});
        wait_rsp("rr_p2a", 6, 100);
        rq[0].push_back({RS_DAT, 1'b1, 8'h30});
        rq[3].push_back({RS_DAT, 1'b1, 8'h33});
        wait_rsp("rr_p2b", 8, 200);
        check("rr_ptr2_first", send_idx[6], 3);
        check("rr_ptr2_second", send_idx[7], 0);

        // non-interleave: req2 arrives during req1's second byte
        clear_logs();
        for (int i = 0; i < 4; i++) rq[1].push_back({RS_DAT, (i == 3), 8'(8'hA0 + i)});
        k = 0;
        while (rsp_idx.size() < 1 && k < 100) begin @(negedge clk); k++; end
        rq[2].push_back({RS_DAT, 1'b1, 8'hB2});
        wait_rsp("nonint", 5, 300);
        for (int i = 0; i < 4; i++) check($sformatf("nonint_idx%0d", i), send_idx[i], 1);
        check("nonint_req2_idx", send_idx[4], 2);
        check("nonint_req2_after_last", int'(send_cyc[4] > rsp_cyc[3]), 1);

        // stall mid-burst
        clear_logs();
        rq[0].push_back({RS_CMD, 1'b0, 8'h01});
        rq[0].push_back({RS_DAT, 1'b0, 8'h02});
        rq[0].push_back({RS_DAT, 1'b1, 8'h03});
        k = 0;
        while (send_idx.size() < 1 && k < 100) begin @(negedge clk); k++; end
        hold[0] = 1'b1;
        wait_rsp("stall_first", 1, 100);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (grant != 4'b0001 || send_en) bad++;
        end
        check("stall_held", bad, 0);
        check("stall_no_issue", send_idx.size(), 1);
        hold[0] = 1'b0;
        wait_rsp("stall_resume", 3, 200);
        check("stall_last_rsp", rsp_dat[2], 'hFC);

        // busy timeout
        clear_logs();
        model_on = 1'b0;
        rq[2].push_back({RS_DAT, 1'b1, 8'h55});
        rq[3].push_back({RS_DAT, 1'b1, 8'h66});
        k = 0;
        while (!err_timeout && k < 300) begin @(negedge clk); k++; end
        model_on = 1'b1;
        check("to_seen", int'(err_timeout), 1);
        wait_rsp("to_next", 1, 200);
        check("to_first_idx", send_idx[0], 2);
        check("to_latency", to_cyc[0] - send_cyc[0], BT);
        check("to_grant_clear", to_grant[0], 0);
        check("to_count", to_cyc.size(), 1);
        check("to_next_idx", rsp_idx[0], 3);
        check("to_next_data", rsp_dat[0], 'h99);

        // reset during WAIT_DONE with master still busy
        clear_logs();
        busy_len = 20;
        rq[0].push_back({RS_CMD, 1'b0, 8'h11});
        rq[0].push_back({RS_DAT, 1'b1, 8'h22});
        k = 0;
        while (!(send_busy && !send_en && grant != 0) && k < 200) begin @(negedge clk); k++; end
        check("rst_reached_wait_done", int'(grant), 1);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("midrst");
        rst = 1'b0;
        busy_len = 3;
        bad = 0;
        k = 0;
        while (send_busy && k < 100) begin
            @(negedge clk);
            if (grant != 0 || send_en || req_ready != 0) bad++;
            k++;
        end
        check("midrst_idle_while_busy", bad, 0);
        k = 0;
        while (send_idx.size() < 2 && k < 100) begin @(negedge clk); k++; end
        check("midrst_reissue_data", send_dat[1], 'h22);
        check("midrst_no_stale_rsp", rsp_idx.size(), 0);
        wait_rsp("midrst_rsp", 1, 100);
        check("midrst_rsp_data", rsp_dat[0], 'hDD);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
